// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU masters, the response consumer
// and the alu_arbiter sequencer.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_ctrl;
    logic [7:0] req0_x;
    logic [7:0] req0_y;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_ctrl;
    logic [7:0] req1_x;
    logic [7:0] req1_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_out;
    logic       rsp_carry;

    modport master (
        output req0_valid, req0_ctrl, req0_x, req0_y,
        output req1_valid, req1_ctrl, req1_x, req1_y,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_carry
    );

    modport slave (
        input  req0_valid, req0_ctrl, req0_x, req0_y,
        input  req1_valid, req1_ctrl, req1_x, req1_y,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_carry
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational 8-bit ALU
// between two requesters; one operation in flight, tagged registered response.
module alu_arbiter #(
    parameter int         CNT_W    = 16,
    parameter logic [3:0] NOP_CTRL = 4'd14
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [3:0]       alu_ctrl,
    output logic [7:0]       alu_x,
    output logic [7:0]       alu_y,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [3:0]       op_ctrl_r;
    logic [7:0]       op_x_r;
    logic [7:0]       op_y_r;
    logic             op_id_r;
    logic             last_grant_r;
    logic             accept_s;
    logic             grant_id_s;
    logic             rsp_fire_s;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [7:0]       rsp_out_r;
    logic             rsp_carry_r;
    logic             busy_r;
    logic [CNT_W-1:0] op_count_r;

    // Grant selection: a tie goes to the requester that was not served last.
    always_comb begin
        accept_s   = 1'b0;
        grant_id_s = 1'b0;
        if (state_r == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                accept_s   = 1'b1;
                grant_id_s = ~last_grant_r;
            end else if (bus.req0_valid) begin
                accept_s   = 1'b1;
                grant_id_s = 1'b0;
            end else if (bus.req1_valid) begin
                accept_s   = 1'b1;
                grant_id_s = 1'b1;
            end else begin
                accept_s   = 1'b0;
                grant_id_s = 1'b0;
            end
        end else begin
            accept_s   = 1'b0;
            grant_id_s = 1'b0;
        end
    end

    assign bus.req0_ready = accept_s & ~grant_id_s;
    assign bus.req1_ready = accept_s &  grant_id_s;
    assign rsp_fire_s     = rsp_valid_r & bus.rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = accept_s ? EXEC : IDLE;
            EXEC:    next_state_s = RESP;
            RESP:    next_state_s = rsp_fire_s ? IDLE : RESP;
            default: next_state_s = IDLE;
        endcase
    end

    // ALU drive: operands only during EXEC, a harmless NOP otherwise.
    always_comb begin
        alu_ctrl = NOP_CTRL;
        alu_x    = 8'd0;
        alu_y    = 8'd0;
        case (state_r)
            EXEC: begin
                alu_ctrl = op_ctrl_r;
                alu_x    = op_x_r;
                alu_y    = op_y_r;
            end
            default: begin
                alu_ctrl = NOP_CTRL;
                alu_x    = 8'd0;
                alu_y    = 8'd0;
            end
        endcase
    end

    // Operand capture on accept and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_ctrl_r    <= 4'd0;
            op_x_r       <= 8'd0;
            op_y_r       <= 8'd0;
            op_id_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            op_ctrl_r    <= grant_id_s ? bus.req1_ctrl : bus.req0_ctrl;
            op_x_r       <= grant_id_s ? bus.req1_x    : bus.req0_x;
            op_y_r       <= grant_id_s ? bus.req1_y    : bus.req0_y;
            op_id_r      <= grant_id_s;
            last_grant_r <= grant_id_s;
        end
    end

    // Response capture at the end of EXEC, plus status flags and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_out_r   <= 8'd0;
            rsp_carry_r <= 1'b0;
            busy_r      <= 1'b0;
            op_count_r  <= '0;
        end else begin
            rsp_valid_r <= (next_state_s == RESP);
            busy_r      <= (next_state_s != IDLE);
            if (state_r == EXEC) begin
                rsp_id_r    <= op_id_r;
                rsp_out_r   <= alu_out;
                rsp_carry_r <= alu_carry;
            end
            if (rsp_fire_s) begin
                op_count_r <= op_count_r + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_out   = rsp_out_r;
    assign bus.rsp_carry = rsp_carry_r;
    assign busy          = busy_r;
    assign op_count      = op_count_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU; a second
// instance with a 2-bit counter free-runs to exercise the counter wrap.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] alu_ctrl, alu2_ctrl;
    logic [7:0] alu_x, alu_y, alu_out, alu2_x, alu2_y, alu2_out;
    logic       alu_carry, alu2_carry, busy, busy2;
    logic [15:0] op_count;
    logic [1:0]  op_count2;

    alu_arbiter_if bus ();
    alu_arbiter_if bus2 ();

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .alu_ctrl(alu2_ctrl), .alu_x(alu2_x), .alu_y(alu2_y),
        .alu_out(alu2_out), .alu_carry(alu2_carry),
        .busy(busy2), .op_count(op_count2)
    );

    // Reference ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, 8 equal.
    function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd8:    return {8'd0, (a == b)};
            default: return 9'h1EE;
        endcase
    endfunction

    assign {alu_carry, alu_out}   = alu_fn(alu_ctrl, alu_x, alu_y);
    assign {alu2_carry, alu2_out} = alu_fn(alu2_ctrl, alu2_x, alu2_y);

    assign bus2.req0_valid = 1'b1;
    assign bus2.req0_ctrl  = 4'd0;
    assign bus2.req0_x     = 8'd1;
    assign bus2.req0_y     = 8'd1;
    assign bus2.req1_valid = 1'b0;
    assign bus2.req1_ctrl  = 4'd0;
    assign bus2.req1_x     = 8'd0;
    assign bus2.req1_y     = 8'd0;
    assign bus2.rsp_ready  = 1'b1;

    typedef struct {
        logic       id;
        logic [3:0] ctrl;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] out;
        logic       carry;
    } vec_t;

    vec_t vecs [9];
    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_x = a; bus.req0_y = b;
        end else begin
            bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_x = a; bus.req1_y = b;
        end
    endtask

    task automatic run_op(input vec_t v);
        int k;
        set_req(v.id, 1'b1, v.ctrl, v.x, v.y);
        settle;
        k = 0;
        while (!(v.id ? bus.req1_ready : bus.req0_ready) && k < 20) begin
            step; settle; k++;
        end
        chk("grant", {31'd0, (v.id ? bus.req1_ready : bus.req0_ready)}, 32'd1);
        chk("other_ready", {31'd0, (v.id ? bus.req0_ready : bus.req1_ready)}, 32'd0);
        step;
        set_req(v.id, 1'b0, 4'd0, 8'd0, 8'd0);
        settle;
        chk("exec_ctrl", {28'd0, alu_ctrl}, {28'd0, v.ctrl});
        chk("exec_x", {24'd0, alu_x}, {24'd0, v.x});
        chk("exec_y", {24'd0, alu_y}, {24'd0, v.y});
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        step; settle;
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, v.id});
        chk("rsp_out", {24'd0, bus.rsp_out}, {24'd0, v.out});
        chk("rsp_carry", {31'd0, bus.rsp_carry}, {31'd0, v.carry});
        step; exp_cnt++; settle;
        chk("op_count", {16'd0, op_count}, exp_cnt);
        chk("done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'd0,  8'd3,    8'd10,  8'd13,  1'b0};
        vecs[1] = '{1'b1, 4'd0,  8'd200,  8'd100, 8'h2C,  1'b1};
        vecs[2] = '{1'b0, 4'd1,  8'd14,   8'd7,   8'd7,   1'b0};
        vecs[3] = '{1'b1, 4'd1,  8'd5,    8'd9,   8'hFC,  1'b1};
        vecs[4] = '{1'b1, 4'd2,  8'hF3,   8'h09,  8'h01,  1'b0};
        vecs[5] = '{1'b0, 4'd3,  8'hF0,   8'h0F,  8'hFF,  1'b0};
        vecs[6] = '{1'b1, 4'd8,  8'hB3,   8'hB3,  8'h01,  1'b0};
        vecs[7] = '{1'b0, 4'd11, 8'h12,   8'h34,  8'hEE,  1'b1};
        vecs[8] = '{1'b0, 4'd4,  8'hAA,   8'h55,  8'hFF,  1'b0};

        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        set_req(1'b1, 1'b0, 4'd0, 8'd0, 8'd0);
        bus.rsp_ready = 1'b1;
        step; step; settle;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_out", {24'd0, bus.rsp_out}, 32'd0);
        chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd14);
        rst_n = 1'b1;
        step;

        // Tie after reset: req0 first, then req1, then req0 again.
        set_req(1'b0, 1'b1, 4'd1, 8'd14, 8'd7);
        set_req(1'b1, 1'b1, 4'd2, 8'hF3, 8'h09);
        settle;
        chk("tie1_r0", {31'd0, bus.req0_ready}, 32'd1);
        chk("tie1_r1", {31'd0, bus.req1_ready}, 32'd0);
        step; bus.req0_valid = 1'b0; settle;
        chk("tie1_exec_r1", {31'd0, bus.req1_ready}, 32'd0);
        step; settle;
        chk("tie1_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("tie1_out", {24'd0, bus.rsp_out}, 32'd7);
        step; exp_cnt++; settle;
        chk("tie1_count", {16'd0, op_count}, exp_cnt);
        chk("tie2_r1", {31'd0, bus.req1_ready}, 32'd1);
        step; bus.req1_valid = 1'b0; settle;
        step; settle;
        chk("tie2_id", {31'd0, bus.rsp_id}, 32'd1);
        chk("tie2_out", {24'd0, bus.rsp_out}, 32'h01);
        step; exp_cnt++; settle;
        set_req(1'b0, 1'b1, 4'd0, 8'd1, 8'd1);
        set_req(1'b1, 1'b1, 4'd0, 8'd2, 8'd2);
        settle;
        chk("tie3_r0", {31'd0, bus.req0_ready}, 32'd1);
        chk("tie3_r1", {31'd0, bus.req1_ready}, 32'd0);
        step; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; settle;
        step; settle;
        chk("tie3_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("tie3_out", {24'd0, bus.rsp_out}, 32'd2);
        step; exp_cnt++; settle;
        chk("tie3_count", {16'd0, op_count}, exp_cnt);

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Backpressure: response held while req1 waits.
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 4'd0, 8'd1, 8'd2);
        settle;
        chk("bp_r0", {31'd0, bus.req0_ready}, 32'd1);
        step;
        set_req(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
        set_req(1'b1, 1'b1, 4'd1, 8'd9, 8'd4);
        step; settle;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_out", {24'd0, bus.rsp_out}, 32'd3);
            chk("bp_id", {31'd0, bus.rsp_id}, 32'd0);
            chk("bp_r1", {31'd0, bus.req1_ready}, 32'd0);
            step; settle;
        end
        bus.rsp_ready = 1'b1; settle;
        chk("bp_r1_resp", {31'd0, bus.req1_ready}, 32'd0);
        step; exp_cnt++; settle;
        chk("bp_count", {16'd0, op_count}, exp_cnt);
        chk("bp_r1_idle", {31'd0, bus.req1_ready}, 32'd1);
        step; set_req(1'b1, 1'b0, 4'd0, 8'd0, 8'd0); settle;
        step; settle;
        chk("bp2_id", {31'd0, bus.rsp_id}, 32'd1);
        chk("bp2_out", {24'd0, bus.rsp_out}, 32'd5);
        step; exp_cnt++; settle;
        chk("bp2_count", {16'd0, op_count}, exp_cnt);

        // Idle drive.
        for (int i = 0; i < 10; i++) begin
            chk("idle_ctrl", {28'd0, alu_ctrl}, 32'd14);
            chk("idle_x", {24'd0, alu_x}, 32'd0);
            chk("idle_y", {24'd0, alu_y}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            step; settle;
        end

        // Reset during EXEC discards the operation.
        set_req(1'b1, 1'b1, 4'd8, 8'hB3, 8'hB3);
        settle;
        chk("mid_r1", {31'd0, bus.req1_ready}, 32'd1);
        step; set_req(1'b1, 1'b0, 4'd0, 8'd0, 8'd0); settle;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step; settle;
        chk("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_count", {16'd0, op_count}, 32'd0);
        chk("mid_busy_rst", {31'd0, busy}, 32'd0);
        chk("mid_alu_ctrl", {28'd0, alu_ctrl}, 32'd14);
        rst_n = 1'b1; exp_cnt = 0;
        step;
        set_req(1'b0, 1'b1, 4'd0, 8'd4, 8'd5);
        set_req(1'b1, 1'b1, 4'd0, 8'd6, 8'd7);
        settle;
        chk("post_r0", {31'd0, bus.req0_ready}, 32'd1);
        chk("post_r1", {31'd0, bus.req1_ready}, 32'd0);
        step; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; settle;
        step; settle;
        chk("post_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("post_out", {24'd0, bus.rsp_out}, 32'd9);
        step; exp_cnt++; settle;
        chk("post_count", {16'd0, op_count}, exp_cnt);

        // Counter wrap on the 2-bit instance: 1, 2, 3, 0, 1.
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int k;
            k = 0;
            while (!bus2.rsp_valid && k < 10) begin
                step; k++;
            end
            chk("wrap_rsp_valid", {31'd0, bus2.rsp_valid}, 32'd1);
            step;
            chk("wrap_count", {30'd0, op_count2}, (i + 1) % 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit `alu` datapath. Accepts operation requests (`ctrl`, `x`, `y`) from two independent masters over valid/ready handshakes. Drives one operation at a time into the combinational ALU and returns the registered result on a single tagged response channel. Sits between the two masters and the `alu` instance; the ALU itself is unchanged.

## Interface
- `CNT_W`, 16, width of the completed-operation counter
- `NOP_CTRL`, 4'd14, ctrl code driven to the ALU when idle
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req0_valid` in 1: requester 0 has an operation
- `req0_ready` out 1: requester 0 operation accepted this cycle
- `req0_ctrl` in 4: requester 0 ALU opcode
- `req0_x`, `req0_y` in 8 each: requester 0 operands
- `req1_valid`, `req1_ready`, `req1_ctrl`, `req1_x`, `req1_y`: same as requester 0, for requester 1
- `alu_ctrl` out 4: to ALU `ctrl`
- `alu_x`, `alu_y` out 8 each: to ALU `x`, `y`
- `alu_out` in 8: from ALU `out`
- `alu_carry` in 1: from ALU `carry`
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: response consumer accepts
- `rsp_id` out 1: requester the response belongs to
- `rsp_out` out 8: captured ALU result
- `rsp_carry` out 1: captured ALU carry
- `busy` out 1: high in any state except IDLE
- `op_count` out CNT_W: completed responses, wraps at 2^CNT_W

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - If any `reqN_valid` is high, grant one requester, assert its `reqN_ready` (combinational, this cycle only) and latch ctrl/x/y and the id into operand registers. Next state is EXEC.
  - With no valid, stay in IDLE.
- **Arbitration:**
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - `last_grant` updates on accept.
- **EXEC:**
  - `alu_ctrl`/`alu_x`/`alu_y` are driven from the operand registers.
  - At the end of the cycle, capture `alu_out` and `alu_carry` into `rsp_out` and `rsp_carry`, and copy the id to `rsp_id`.
  - Next state is RESP.
- **RESP:**
  - `rsp_valid` is 1.
  - Hold `rsp_out`, `rsp_carry` and `rsp_id` stable until `rsp_ready` is high. On that cycle, increment `op_count` and go to IDLE.
  - No new request is accepted while in RESP.
- **ALU outputs outside EXEC:** `alu_ctrl` = NOP_CTRL and `alu_x` = `alu_y` = 0.
- **Opcode handling:** opcodes pass through unchecked. Undefined codes (e.g. 11, 13, 15) return whatever the ALU produces.
- **Ready independence:** `reqN_ready` never depends on `rsp_ready`, and never goes high for both requesters in the same cycle.
- **Reset:** on `rst_n` = 0 at a rising edge:
  - state goes to IDLE;
  - `rsp_valid`, `rsp_id`, `rsp_out`, `rsp_carry`, `busy`, `op_count` go to 0;
  - operand registers go to 0 and `last_grant` to 1;
  - an in-flight operation is discarded with no response.

## Timing
- Accept at cycle N (valid & ready high at edge N).
- ALU is driven during cycle N+1.
- `rsp_valid` rises at edge N+2.
- Best-case throughput is one operation per 3 cycles (accept, EXEC, RESP with `rsp_ready` already high). The next accept can happen at the earliest on cycle N+3.
- Requester handshake: the masters hold valid and payload until ready. A requester may drop valid before it is granted; that request is simply not served.
- `rsp_ready` held low stalls indefinitely in RESP. Requests wait with ready low.
- `op_count` increments exactly once per response handshake. It wraps from 2^CNT_W−1 to 0.
- `busy` is registered from state: high from the edge after accept until the edge that returns to IDLE.

## Test plan
- **Single requester, add:** req0 ctrl=0, x=3, y=10 with `rsp_ready`=1.
  - `req0_ready` is high 1 cycle.
  - `alu_ctrl`=0 in the following cycle.
  - `rsp_valid` 2 cycles after accept, with `rsp_id`=0, `rsp_out`=13, `rsp_carry`=0.
  - `op_count`=1.
- **Simultaneous requests, alternating grants:** both requesters valid, req0 sub x=14 y=7, req1 and x=8'b11110011 y=8'b00001001.
  - First response is id 0, out=7.
  - Second response is id 1, out=8'b00000001.
  - Then both requesters re-request: req0 wins again. `last_grant` now =1 (req1), so req0 is the non-last requester.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP while req1 is valid.
  - `rsp_out`/`rsp_id` stay stable.
  - `req1_ready` stays low.
  - After `rsp_ready` goes high, req1 is accepted in the next IDLE cycle.
- **Idle drive:** no valids for 10 cycles.
  - `alu_ctrl`=14, `alu_x`=`alu_y`=0, `busy`=0, `rsp_valid`=0 throughout.
- **Reset mid-operation:** accept req1 equal x=y=8'b10110011, then assert `rst_n`=0 in EXEC.
  - Next edge shows IDLE with `rsp_valid`=0 and `op_count`=0.
  - After release, req0 wins a tie.
- **Counter wrap:** with CNT_W=2, complete 5 operations.
  - `op_count` sequence is 1, 2, 3, 0, 1.
